// File: rtl/pc_reg_pkg.sv
// Core-wide constants shared by the fetch stage and the PC register.
// The fetch stage builds its next-PC mux from the same values.
package pc_reg_pkg;

    localparam int unsigned XLEN = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    // Instructions are 4-byte aligned; any set bit in [1:0] is a misaligned fetch.
    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter register of the fetch stage: holds the current PC, the PC before the
// last committed write, and a valid flag that rises on the first edge after reset release.
module pc_reg #(
    parameter int unsigned XLEN = pc_reg_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(pc_reg_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wen,
    input  logic [XLEN-1:0] pc_src,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_prev,
    output logic            pc_valid,
    output logic            misalign
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_prev_q;
    logic            valid_q;

    // pc_src is committed verbatim: alignment and wrap are the fetch stage's concern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            pc_prev_q <= RESET_PC;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            if (wen) begin
                pc_q      <= pc_src;
                pc_prev_q <= pc_q;
            end
        end
    end

    assign pc_out   = pc_q;
    assign pc_prev  = pc_prev_q;
    assign pc_valid = valid_q;
    assign misalign = pc_reg_pkg::pc_misaligned(pc_q[1:0]);

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: a reference model pushes expected state into a
// scoreboard each cycle; feature tasks pop and compare after the clock edge.
module tb_pc_reg;

    localparam logic [63:0] BOOT = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] prev;
        logic        valid;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wen = 1'b0;
    logic [63:0] pc_src = '0;
    logic [63:0] pc_out;
    logic [63:0] pc_prev;
    logic        pc_valid;
    logic        misalign;

    int vectors = 0;
    int miscompares = 0;

    exp_t        sb[$];
    logic [63:0] m_pc = BOOT;
    logic [63:0] m_prev = BOOT;
    logic        m_valid = 1'b0;

    pc_reg dut (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .pc_src   (pc_src),
        .pc_out   (pc_out),
        .pc_prev  (pc_prev),
        .pc_valid (pc_valid),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, advance the model, settle past the rising edge.
    task automatic step(input logic r, input logic w, input logic [63:0] src);
        exp_t e;
        @(negedge clk);
        rst = r;
        wen = w;
        pc_src = src;
        if (!r) begin
            m_pc = BOOT;
            m_prev = BOOT;
            m_valid = 1'b0;
        end else begin
            if (w) begin
                m_prev = m_pc;
                m_pc = src;
            end
            m_valid = 1'b1;
        end
        e.pc = m_pc;
        e.prev = m_prev;
        e.valid = m_valid;
        e.mis = (m_pc[1:0] != 2'b00);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 64'h1234);
            e = sb.pop_front();
            vectors++;
            if ({pc_out, pc_prev, pc_valid, misalign} !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got pc=%h prev=%h v=%b m=%b, want pc=%h prev=%h v=%b m=%b",
                         i, pc_out, pc_prev, pc_valid, misalign, e.pc, e.prev, e.valid, e.mis);
            end
        end
    endtask

    task automatic test_sequential();
        exp_t e;
        logic [63:0] srcs [2];
        srcs[0] = 64'h8000_0004;
        srcs[1] = 64'h8000_0008;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, srcs[i]);
            e = sb.pop_front();
            vectors++;
            if ({pc_out, pc_prev, pc_valid, misalign} !== e) begin
                miscompares++;
                $display("FAIL seq[%0d]: got pc=%h prev=%h v=%b m=%b, want pc=%h prev=%h v=%b m=%b",
                         i, pc_out, pc_prev, pc_valid, misalign, e.pc, e.prev, e.valid, e.mis);
            end
        end
        vectors++;
        if (pc_prev !== 64'h8000_0004 || pc_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL seq_end: got prev=%h v=%b, want prev=%h v=1",
                     pc_prev, pc_valid, 64'h8000_0004);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, {$urandom, $urandom});
            e = sb.pop_front();
            vectors++;
            if ({pc_out, pc_prev, pc_valid, misalign} !== e) begin
                miscompares++;
                $display("FAIL stall[%0d]: got pc=%h prev=%h v=%b m=%b, want pc=%h prev=%h v=%b m=%b",
                         i, pc_out, pc_prev, pc_valid, misalign, e.pc, e.prev, e.valid, e.mis);
            end
        end
        vectors++;
        if (pc_out !== 64'h8000_0008 || pc_prev !== 64'h8000_0004) begin
            miscompares++;
            $display("FAIL stall_hold: got pc=%h prev=%h, want pc=%h prev=%h",
                     pc_out, pc_prev, 64'h8000_0008, 64'h8000_0004);
        end
    endtask

    task automatic test_jump_misalign();
        exp_t e;
        logic [63:0] srcs [3];
        srcs[0] = 64'h8000_0102;
        srcs[1] = 64'h8000_0100;
        srcs[2] = 64'h8000_0040;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, srcs[i]);
            e = sb.pop_front();
            vectors++;
            if ({pc_out, pc_prev, pc_valid, misalign} !== e) begin
                miscompares++;
                $display("FAIL jump[%0d]: got pc=%h prev=%h v=%b m=%b, want pc=%h prev=%h v=%b m=%b",
                         i, pc_out, pc_prev, pc_valid, misalign, e.pc, e.prev, e.valid, e.mis);
            end
            if (i == 0) begin
                vectors++;
                if (misalign !== 1'b1) begin
                    miscompares++;
                    $display("FAIL jump_misalign: got %b, want 1", misalign);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        // Assert reset mid-high-phase, well away from either clock edge.
        #2;
        rst = 1'b0;
        m_pc = BOOT;
        m_prev = BOOT;
        m_valid = 1'b0;
        #1;
        vectors++;
        if (pc_out !== BOOT || pc_prev !== BOOT || pc_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got pc=%h prev=%h v=%b, want pc=%h prev=%h v=0",
                     pc_out, pc_prev, pc_valid, BOOT, BOOT);
        end
        // A write pending while reset is held must be lost.
        step(1'b0, 1'b1, 64'hDEAD_BEE0);
        e = sb.pop_front();
        vectors++;
        if ({pc_out, pc_prev, pc_valid, misalign} !== e) begin
            miscompares++;
            $display("FAIL reset_hold: got pc=%h prev=%h v=%b m=%b, want pc=%h prev=%h v=%b m=%b",
                     pc_out, pc_prev, pc_valid, misalign, e.pc, e.prev, e.valid, e.mis);
        end
        // First edge after release obeys wen = 0 yet still raises valid.
        step(1'b1, 1'b0, 64'h1111_2222);
        e = sb.pop_front();
        vectors++;
        if ({pc_out, pc_prev, pc_valid, misalign} !== e) begin
            miscompares++;
            $display("FAIL release: got pc=%h prev=%h v=%b m=%b, want pc=%h prev=%h v=%b m=%b",
                     pc_out, pc_prev, pc_valid, misalign, e.pc, e.prev, e.valid, e.mis);
        end
    endtask

    task automatic test_width_edge();
        exp_t e;
        logic [63:0] srcs [3];
        srcs[0] = 64'hFFFF_FFFF_FFFF_FFFC;
        srcs[1] = 64'hFFFF_FFFF_FFFF_FFFC;  // same as current: prev must still update
        srcs[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, srcs[i]);
            e = sb.pop_front();
            vectors++;
            if ({pc_out, pc_prev, pc_valid, misalign} !== e) begin
                miscompares++;
                $display("FAIL width[%0d]: got pc=%h prev=%h v=%b m=%b, want pc=%h prev=%h v=%b m=%b",
                         i, pc_out, pc_prev, pc_valid, misalign, e.pc, e.prev, e.valid, e.mis);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump_misalign();
        test_async_reset();
        test_width_edge();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
